// File: rtl/flow_status_unit.sv
// Program-flow/status stage: holds the status register, resolves conditional
// jumps into a redirect pulse plus fixed-length fetch flush, and manages trap mode.
module flow_status_unit #(
    parameter int unsigned WORD_W       = 20,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_zero,
    input  logic              in_sign,
    input  logic              in_carry,
    input  logic [WORD_W-1:0] in_operand,
    input  logic              trap_clear,
    output logic [3:0]        status,
    output logic              br_valid,
    output logic [WORD_W-1:0] br_target,
    output logic              flush,
    output logic              trapped,
    output logic [1:0]        trap_cause
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned SR_W    = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_ALU  = 4'd1;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd2;
    localparam logic [OP_W-1:0] OP_JZ   = 4'd3;
    localparam logic [OP_W-1:0] OP_JS   = 4'd4;
    localparam logic [OP_W-1:0] OP_JZS  = 4'd5;
    localparam logic [OP_W-1:0] OP_LSR  = 4'd6;
    localparam logic [OP_W-1:0] OP_XSR  = 4'd7;
    localparam logic [OP_W-1:0] OP_TRAP = 4'd8;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_TRAP    = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b10;

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;

    logic                accept_c;
    logic                taken_c;
    logic                illegal_c;
    logic                trap_op_c;

    logic [SR_W-1:0]     status_nxt;
    logic                br_valid_nxt;
    logic [WORD_W-1:0]   br_target_nxt;
    logic [CAUSE_W-1:0]  cause_nxt;

    assign in_ready = (state == ST_RUN);

    // Beat decode; jump conditions read the registered SR.
    always_comb begin
        accept_c  = in_valid & (state == ST_RUN);
        illegal_c = (in_op > OP_TRAP);
        trap_op_c = (in_op == OP_TRAP) & status[3];
        taken_c   = 1'b0;
        case (in_op)
            OP_JMP:  taken_c = 1'b1;
            OP_JZ:   taken_c = status[0];
            OP_JS:   taken_c = status[1];
            OP_JZS:  taken_c = status[0] | status[1];
            default: taken_c = 1'b0;
        endcase
    end

    // State register (plus flush counter).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (accept_c) begin
                    if (taken_c) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FLUSH_LOAD;
                    end else if (trap_op_c || illegal_c) begin
                        state_nxt = ST_TRAP;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_TRAP: begin
                if (trap_clear) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output next-values: SR updates, redirect, trap cause.
    always_comb begin
        status_nxt    = status;
        br_valid_nxt  = 1'b0;
        br_target_nxt = br_target;
        cause_nxt     = trap_cause;
        if (accept_c) begin
            case (in_op)
                OP_NOP:  status_nxt = status;
                OP_ALU:  status_nxt = {status[3], in_carry, in_sign, in_zero};
                OP_LSR:  status_nxt = in_operand[SR_W-1:0];
                OP_XSR:  status_nxt = status ^ in_operand[SR_W-1:0];
                default: status_nxt = status;
            endcase
            if (taken_c) begin
                br_valid_nxt  = 1'b1;
                br_target_nxt = in_operand;
            end
            if (trap_op_c) begin
                cause_nxt = CAUSE_TRAP;
            end else if (illegal_c) begin
                cause_nxt = CAUSE_ILLEGAL;
            end
        end
        if ((state == ST_TRAP) && trap_clear) begin
            cause_nxt = CAUSE_NONE;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status     <= '0;
            br_valid   <= 1'b0;
            br_target  <= '0;
            flush      <= 1'b0;
            trapped    <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            status     <= status_nxt;
            br_valid   <= br_valid_nxt;
            br_target  <= br_target_nxt;
            flush      <= (state_nxt == ST_FLUSH);
            trapped    <= (state_nxt == ST_TRAP);
            trap_cause <= cause_nxt;
        end
    end

endmodule
